bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-decimal code converter. It is the next generation of the team's 4-bit combinational code converters. It accepts a WIDTH-bit unsigned binary word over a valid/ready handshake and runs the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It presents DIGITS decimal digits, either as 8421 BCD or as excess-3, together with an overflow flag. It sits between datapath results and display/reporting logic.

---
 rtl/bin_to_bcd_pkg.sv | 25 ++
 rtl/bcd_digit_adj.sv | 39 +++
 rtl/bin_to_bcd_seq.sv | 143 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_pkg
// Description : Shared types and constants for the sequential binary-to-
//               decimal converter (FSM state encoding, digit width, the
//               double-dabble adjust constants and the output-mode codes).
// Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int                 DIGIT_W    = 4;
    localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;
    localparam logic [DIGIT_W-1:0] XS3_OFFSET = 4'd3;
    localparam logic               MODE_BCD   = 1'b0;
    localparam logic               MODE_XS3   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Combinational 4-bit digit cell: o_digit = i_digit + ADD when
//               enabled and i_digit >= THRESH, otherwise i_digit unchanged.
//               THRESH=5/ADD=3 is the double-dabble correction; THRESH=0
//               turns it into an unconditional offset (excess-3 output).
// Ports       : i_en    - enables the addition
//               i_digit - input digit
//               o_digit - adjusted digit (4-bit wrap)
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bin_to_bcd_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] THRESH = ADJ_THRESH,
    parameter logic [DIGIT_W-1:0] ADD    = ADJ_ADD
) (
    input  logic               i_en,
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    logic w_ge;

    // A zero threshold means "always"; elaborate it away rather than
    // comparing an unsigned value against zero.
    generate
        if (THRESH == '0) begin : g_always
            assign w_ge = 1'b1;
        end else begin : g_cmp
            assign w_ge = (i_digit >= THRESH);
        end
    endgenerate

    assign o_digit = (i_en && w_ge) ? (i_digit + ADD) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Sequential binary-to-decimal converter using shift-and-add-3
//               (double dabble), one input bit per clock. Result is DIGITS
//               digits in 8421 BCD or excess-3, plus an overflow flag when
//               the value does not fit in DIGITS digits (value mod 10^DIGITS
//               is then presented).
// Ports       : clk, rst (async, active high)
//               in_valid/in_ready/in_bin/in_mode - input handshake
//               out_valid/out_ready/out_dec/out_ovf - result handshake
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_dec,
    output logic                  out_ovf
);

    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH);

    state_t               r_state;
    state_t               w_state_next;
    logic [SR_W-1:0]      r_sr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_mode;
    logic                 r_ovf;
    logic [BCD_W-1:0]     r_out_dec;
    logic                 r_out_ovf;

    logic [BCD_W-1:0]     w_adj_bcd;
    logic [SR_W-1:0]      w_sr_adj;
    logic [SR_W-1:0]      w_sr_shift;
    logic                 w_carry;
    logic [BCD_W-1:0]     w_xs3;
    logic                 w_conv_last;

    // Per-digit double-dabble correction on the BCD half of the register,
    // and the excess-3 offset on the final digits feeding the output register.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit_adj #(
                .THRESH (ADJ_THRESH),
                .ADD    (ADJ_ADD)
            ) u_adj (
                .i_en    (1'b1),
                .i_digit (r_sr[WIDTH + DIGIT_W*gi +: DIGIT_W]),
                .o_digit (w_adj_bcd[DIGIT_W*gi +: DIGIT_W])
            );

            bcd_digit_adj #(
                .THRESH ('0),
                .ADD    (XS3_OFFSET)
            ) u_xs3 (
                .i_en    (r_mode == MODE_XS3),
                .i_digit (r_sr[WIDTH + DIGIT_W*gi +: DIGIT_W]),
                .o_digit (w_xs3[DIGIT_W*gi +: DIGIT_W])
            );
        end
    endgenerate

    assign w_sr_adj    = {w_adj_bcd, r_sr[WIDTH-1:0]};
    assign w_sr_shift  = {w_sr_adj[SR_W-2:0], 1'b0};
    // A bit leaving the top digit means the running value passed 10^DIGITS.
    assign w_carry     = w_sr_adj[SR_W-1];
    // The cycle after the last shift only registers the result.
    assign w_conv_last = (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_state_next = CONV;
            CONV:    if (w_conv_last) w_state_next = DONE;
            DONE:    if (out_ready)   w_state_next = IDLE;
            default:                  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_mode    <= MODE_BCD;
            r_ovf     <= 1'b0;
            r_out_dec <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sr   <= {{BCD_W{1'b0}}, in_bin};
                        r_mode <= in_mode;
                        r_cnt  <= '0;
                        r_ovf  <= 1'b0;
                    end
                end
                CONV: begin
                    if (w_conv_last) begin
                        r_out_dec <= w_xs3;
                        r_out_ovf <= r_ovf;
                    end else begin
                        r_sr  <= w_sr_shift;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_carry) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_dec   = r_out_dec;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd_seq
// Description : Directed self-checking bench for bin_to_bcd_seq with two
//               instances: WIDTH=8/DIGITS=3 and WIDTH=8/DIGITS=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;

    logic        iv3, ir3, im3, ov3, or3, ovf3;
    logic [7:0]  ib3;
    logic [11:0] od3;

    logic        iv2, ir2, im2, ov2, or2, ovf2;
    logic [7:0]  ib2;
    logic [7:0]  od2;

    int n_asserts;
    int n_fail;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .in_bin    (ib3),
        .in_mode   (im3),
        .out_valid (ov3),
        .out_ready (or3),
        .out_dec   (od3),
        .out_ovf   (ovf3)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .in_bin    (ib2),
        .in_mode   (im2),
        .out_valid (ov2),
        .out_ready (or2),
        .out_dec   (od2),
        .out_ovf   (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits of v (mod 10^nd), optional +3 per digit.
    function automatic logic [11:0] ref_dec(input int v, input bit m, input int nd);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int d = 0; d < nd; d++) begin
            r[4*d +: 4] = 4'(x % 10) + (m ? 4'd3 : 4'd0);
            x = x / 10;
        end
        return r;
    endfunction

    // One full conversion on the selected instance: accept, latency check,
    // result check, consume.
    task automatic run(input bit two, input int v, input bit m,
                       input logic [11:0] exp_dec, input logic exp_ovf, input string tag);
        int lat;
        check({tag, "_rdy"}, {31'd0, two ? ir2 : ir3}, 32'd1);
        if (two) begin iv2 = 1'b1; ib2 = 8'(v); im2 = m; end
        else     begin iv3 = 1'b1; ib3 = 8'(v); im3 = m; end
        tick();
        // Inputs are free to change after the accept edge.
        if (two) begin iv2 = 1'b0; ib2 = 8'($urandom); im2 = ~m; end
        else     begin iv3 = 1'b0; ib3 = 8'($urandom); im3 = ~m; end
        lat = 0;
        while (!(two ? ov2 : ov3) && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd9);
        check({tag, "_dec"}, two ? {24'd0, od2} : {20'd0, od3}, {20'd0, exp_dec});
        check({tag, "_ovf"}, {31'd0, two ? ovf2 : ovf3}, {31'd0, exp_ovf});
        if (two) or2 = 1'b1; else or3 = 1'b1;
        tick();
        if (two) or2 = 1'b0; else or3 = 1'b0;
        check({tag, "_consumed"}, {30'd0, two ? ov2 : ov3, two ? ir2 : ir3}, 32'b01);
    endtask

    initial begin
        int lat;
        n_asserts = 0;
        n_fail    = 0;
        rst = 1'b1;
        iv3 = 1'b0; ib3 = '0; im3 = 1'b0; or3 = 1'b0;
        iv2 = 1'b0; ib2 = '0; im2 = 1'b0; or2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_ready", {31'd0, ir3}, 32'd1);
        check("rst_valid", {31'd0, ov3}, 32'd0);
        check("rst_dec",   {20'd0, od3}, 32'd0);
        check("rst_ovf",   {31'd0, ovf3}, 32'd0);

        // Directed vectors, DIGITS=3
        run(1'b0, 255, 1'b0, 12'h255, 1'b0, "d3_255_bcd");
        run(1'b0, 255, 1'b1, 12'h588, 1'b0, "d3_255_xs3");
        run(1'b0,   0, 1'b0, 12'h000, 1'b0, "d3_0_bcd");
        run(1'b0,   0, 1'b1, 12'h333, 1'b0, "d3_0_xs3");
        run(1'b0,   9, 1'b0, 12'h009, 1'b0, "d3_9_bcd");
        run(1'b0,   9, 1'b1, 12'h33C, 1'b0, "d3_9_xs3");

        // Directed vectors, DIGITS=2 (overflow boundary)
        run(1'b1, 123, 1'b0, 12'h023, 1'b1, "d2_123_bcd");
        run(1'b1,  99, 1'b0, 12'h099, 1'b0, "d2_99_bcd");
        run(1'b1, 100, 1'b0, 12'h000, 1'b1, "d2_100_bcd");
        run(1'b1, 123, 1'b1, 12'h056, 1'b1, "d2_123_xs3");

        // Backpressure: hold result while a new word is offered
        iv3 = 1'b1; ib3 = 8'd37; im3 = 1'b0;
        tick();
        iv3 = 1'b0;
        lat = 0;
        while (!ov3 && lat < 40) begin tick(); lat++; end
        check("bp_lat", 32'(lat), 32'd9);
        iv3 = 1'b1; ib3 = 8'd200; im3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'd0, ov3}, 32'd1);
            check("bp_hold_dec",   {20'd0, od3}, 32'h037);
            check("bp_hold_ready", {31'd0, ir3}, 32'd0);
            tick();
        end
        or3 = 1'b1;
        tick();
        or3 = 1'b0;
        check("bp_consume_valid", {31'd0, ov3}, 32'd0);
        check("bp_consume_ready", {31'd0, ir3}, 32'd1);
        tick();
        check("bp_next_accepted", {31'd0, ir3}, 32'd0);
        iv3 = 1'b0; ib3 = 8'd0;
        lat = 0;
        while (!ov3 && lat < 40) begin tick(); lat++; end
        check("bp_next_lat", 32'(lat), 32'd9);
        check("bp_next_dec", {20'd0, od3}, 32'h200);
        or3 = 1'b1;
        tick();
        or3 = 1'b0;

        // Reset during the third CONV cycle; previous result (0x200) must clear
        iv3 = 1'b1; ib3 = 8'd255; im3 = 1'b0;
        tick();
        iv3 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #2;
        check("midrst_valid", {31'd0, ov3}, 32'd0);
        check("midrst_dec",   {20'd0, od3}, 32'd0);
        check("midrst_ready", {31'd0, ir3}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        check("postrst_valid", {31'd0, ov3}, 32'd0);
        check("postrst_dec",   {20'd0, od3}, 32'd0);
        check("postrst_ready", {31'd0, ir3}, 32'd1);
        run(1'b0, 200, 1'b0, 12'h200, 1'b0, "postrst_200");

        // Sweep both instances, both modes
        for (int v = 0; v < 256; v++) begin
            for (int m = 0; m < 2; m++) begin
                run(1'b0, v, m[0], ref_dec(v, m[0], 3), 1'b0, "sweep_d3");
                run(1'b1, v, m[0], ref_dec(v, m[0], 2), (v >= 100), "sweep_d2");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
